// File: rtl/block_ripple_subtractor.sv
// Multi-cycle W-bit subtractor: diff = a - b, one BLK-bit ripple block per clock.
// Optional signed overflow flag (port ovf) when SUB_OVERFLOW_EN is defined.
module block_ripple_subtractor #(
  parameter int unsigned W   = 128,
  parameter int unsigned BLK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned NBLK  = W / BLK;
  localparam int unsigned IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [IDX_W-1:0] r_idx;

  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_base;
  logic [BLK-1:0]   w_a_blk;
  logic [BLK-1:0]   w_b_blk;
  logic [BLK:0]     w_sum;
  logic [BLK-1:0]   w_blk_diff;
  logic             w_bout_blk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_idx == LAST_IDX) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);

  // Captured operands stay intact; the current block is selected by shifting a copy.
  assign w_base  = 32'(r_idx) * BLK;
  assign w_a_blk = BLK'(r_a >> w_base);
  assign w_b_blk = BLK'(r_b >> w_base);

  // a - b - borrow computed as a + ~b + ~borrow; borrow out is the inverted carry.
  assign w_sum      = {1'b0, w_a_blk} + {1'b0, ~w_b_blk} + {{BLK{1'b0}}, ~r_borrow};
  assign w_blk_diff = w_sum[BLK-1:0];
  assign w_bout_blk = ~w_sum[BLK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_idx    <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_idx    <= '0;
    end else if (r_state == RUN) begin
      r_diff   <= r_diff | (W'(w_blk_diff) << w_base);
      r_borrow <= w_bout_blk;
      r_idx    <= r_idx + 1'b1;
      if (w_last) r_bout <= w_bout_blk;
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_ovf <= 1'b0;
    else if (w_accept) r_ovf <= 1'b0;
    else if (w_last)   r_ovf <= (r_a[W-1] != r_b[W-1]) && (w_blk_diff[BLK-1] != r_a[W-1]);
  end

  assign ovf = r_ovf;
`endif

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_block_ripple_subtractor.sv
// Bench for block_ripple_subtractor: vector table plus abort/ignore/held-start sequences.
// Expected results queue up at start and are compared when done pulses.
module tb_block_ripple_subtractor;

  localparam int unsigned W    = 128;
  localparam int unsigned BLK  = 4;
  localparam int unsigned NBLK = W / BLK;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  block_ripple_subtractor #(.W(W), .BLK(BLK)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] t;
    t    = {1'b0, x} - {1'b0, y};
    e.d  = t[W-1:0];
    e.bo = t[W];
    e.ov = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] d, input logic bo, input logic ov);
    vec_t v;
    v.a    = x;
    v.b    = y;
    v.e.d  = d;
    v.e.bo = bo;
    v.e.ov = ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e,
                          input bit push);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc);
    bit busy_ok;
    busy_ok = 1'b1;
    cyc     = cyc0;
    while (!done && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    check("busy_in_run", busy_ok, 1'b1);
  endtask

  task automatic finish_op(input string tag, input int cyc);
    exp_t e;
    check({tag, "_latency"}, cyc, NBLK);
    if (!done) begin
      check({tag, "_done"}, done, 1'b1);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      return;
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s_scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_diff"}, diff, e.d);
    check({tag, "_bout"}, bout, e.bo);
`ifdef SUB_OVERFLOW_EN
    check({tag, "_ovf"}, ovf, e.ov);
`endif
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_hold"}, diff, e.d);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input exp_t e);
    int cyc;
    start_op(x, y, e, 1'b1);
    wait_done(0, cyc);
    finish_op(tag, cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] msb;
    logic [W-1:0] mask;
    logic [W-1:0] x1;
    logic [W-1:0] y1;
    exp_t         e1;
    exp_t         e6;
    bit           saw;
    int           cyc;

    ones = '1;
    msb  = {1'b1, {(W-1){1'b0}}};
    vecs[0] = mk(128'd5, 128'd3, 128'd2, 1'b0, 1'b0);
    vecs[1] = mk(128'd0, 128'd1, ones, 1'b1, 1'b0);
    vecs[2] = mk(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '0, 1'b0, 1'b0);
    vecs[3] = mk(128'h1_0000_0000_0000_0000, 128'd1, 128'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    vecs[4] = mk(msb, 128'd1, ~msb, 1'b0, 1'b1);
    vecs[5] = mk(128'd3, 128'd1, 128'd2, 1'b0, 1'b0);
    vecs[6] = mk(ones, ~msb, msb, 1'b0, 1'b0);
    vecs[7] = mk(~msb, msb, ones, 1'b1, 1'b1);
    for (int i = 8; i < 12; i++) begin
      vecs[i].a = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].b = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].e = model(vecs[i].a, vecs[i].b);
    end

    #1 rst = 1'b1;
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, '0);
    check("rst_bout", bout, 1'b0);
`ifdef SUB_OVERFLOW_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 12; i++) do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].e);

    // Second start and new operands mid-run must be ignored.
    x1 = {32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
    y1 = {32'h1234_5678, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001};
    e1 = model(x1, y1);
    start_op(x1, y1, e1, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    a     = ~x1;
    b     = ~y1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mask  = ones >> (W - 10 * BLK);
    check("mid_busy", busy, 1'b1);
    check("mid_done", done, 1'b0);
    check("mid_partial", diff, e1.d & mask);
    wait_done(10, cyc);
    finish_op("ignore", cyc);

    // Reset at cycle 15 of a run aborts it without a done pulse.
    start_op(ones, '0, e1, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    check("abort_busy_pre", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, '0);
    check("abort_bout", bout, 1'b0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw = 1'b1;
    end
    check("abort_no_done", saw, 1'b0);
    e6.d  = 128'd6;
    e6.bo = 1'b0;
    e6.ov = 1'b0;
    do_op("after_rst", 128'd10, 128'd4, e6);

    // start held high: restart on the first IDLE edge after done.
    e1 = model(vecs[8].a, vecs[9].b);
    @(negedge clk);
    a     = vecs[8].a;
    b     = vecs[9].b;
    start = 1'b1;
    exp_q.push_back(e1);
    exp_q.push_back(e1);
    @(posedge clk);
    #1;
    wait_done(0, cyc);
    finish_op("held1", cyc);
    @(posedge clk);
    #1;
    check("held_restart", busy, 1'b1);
    start = 1'b0;
    wait_done(0, cyc);
    finish_op("held2", cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/block_ripple_subtractor.md
BLOCK_RIPPLE_SUBTRACTOR -- requirements
Module: block_ripple_subtractor

Interface
REQ-001 SHALL have parameter W, default 128: operand and result width in bits.
REQ-002 SHALL have parameter BLK, default 4: block width in bits processed per cycle; W SHALL be an integer multiple of BLK.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1: request to begin a subtraction; sampled only in IDLE.
REQ-006 SHALL have ports a and b, input, W each: minuend and subtrahend; captured when start is accepted.
REQ-007 SHALL have port busy, output, 1: high in RUN and DONE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse; result valid while high and held afterwards.
REQ-009 SHALL have port diff, output, W: result a - b mod 2^W.
REQ-010 SHALL have port bout, output, 1: final borrow, 1 when a < b unsigned.
REQ-011 SHALL have port ovf, output, 1, present only with REQ-025 macro: signed two's-complement overflow.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 In IDLE with start=1 at an edge: SHALL register a and b, clear the borrow register to 0 and the block index to 0, then enter RUN.
REQ-014 In RUN, each edge SHALL process block i: diff[(i+1)*BLK-1 : i*BLK] = a_blk - b_blk - borrow. The borrow register takes the block's borrow-out, and i increments.
REQ-015 Block arithmetic SHALL be a BLK-bit ripple subtract: a + ~b + ~borrow_in per block, with borrow_out = NOT carry_out.
REQ-016 After block W/BLK-1 is processed, the FSM SHALL enter DONE on that same edge, with bout = final borrow.
REQ-017 Latency: with start accepted at edge 0, done SHALL be high from edge W/BLK until edge W/BLK+1, giving 32 cycles at default parameters. At edge W/BLK+1 the FSM SHALL return to IDLE.
REQ-018 start while in RUN or DONE SHALL be ignored, and SHALL NOT alter captured operands.
REQ-019 Changes on a or b after capture SHALL NOT affect the result.
REQ-020 diff and bout SHALL hold their last values in IDLE until the next accepted start.
REQ-021 Result bits of blocks not yet processed SHALL read 0 during RUN.
REQ-022 start held high continuously SHALL start a new operation on the first IDLE edge, one cycle after done.

Reset
REQ-023 On rst=1, asynchronously: the FSM SHALL go to IDLE; busy, done, bout, ovf, diff, the borrow register, the block index and the captured operands SHALL all be 0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro SUB_OVERFLOW_EN.
- Defined: port ovf exists, computed at the last block as (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), registered with bout, reset to 0.
- Undefined: port ovf and its logic SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-026 a=5, b=3, start pulse -> done high exactly 32 cycles after the start edge; diff=2, bout=0.
REQ-027 a=0, b=1 -> diff=all ones (2^128-1), bout=1.
REQ-028 a=b=0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> diff=0, bout=0. Also a=2^64, b=1 -> diff=2^64-1, bout=0, exercising borrow ripple across 16 blocks.
REQ-029 Second start pulse and changed a/b at cycle 10 of RUN -> ignored; result matches the first operands; busy stays high with no early done.
REQ-030 rst pulse at cycle 15 of RUN -> busy=0, diff=0, no done. A new start with a=10, b=4 -> diff=6 after 32 cycles.
REQ-031 With SUB_OVERFLOW_EN: a=0x8000…0, b=1 -> diff=0x7FFF…F, ovf=1, bout=0. Also a=3, b=1 -> ovf=0.
